uart_out_port: RTL and testbench
================================

// Module: uart_out_port
// PURPOSE
//  Output peripheral downstream of the CPU output register (reg_out_o). Each CPU
//  write strobe queues the 8-bit output value in a small FIFO. Queued bytes are
//  serialized as 8N1 UART frames on tx_o, so program output is observable on a
//  single pin and in the test bench.
// PARAMETERS
//  DATA_W        8   byte width; fixed at 8 for 8N1 framing
//  FIFO_DEPTH    4   FIFO entries; power of two, >= 2
//  CLKS_PER_BIT  4   clk_i cycles per UART bit; >= 2. Keep small in simulation.
// PORTS
//  clk_i       in   1                  system clock; all logic on the rising edge
//  rst_i       in   1                  synchronous, active-high reset
//  data_i      in   DATA_W             byte from the CPU output register
//  wr_i        in   1                  write strobe; one byte per high cycle
//  tx_o        out  1                  serial line; idles high
//  busy_o      out  1                  high when a frame is in flight or the FIFO is non-empty
//  full_o      out  1                  high when FIFO count == FIFO_DEPTH
//  level_o     out  $clog2(FIFO_DEPTH)+1  current FIFO count
//  overflow_o  out  1                  sticky: a write was dropped
// BEHAVIOUR
//  Reset values: tx_o=1, busy_o=0, full_o=0, level_o=0, overflow_o=0.
//   FIFO is emptied, FSM goes to IDLE, bit and baud counters are cleared.
//  Reset mid-frame: the frame is aborted. tx_o is 1 after the reset edge; no
//   partial frame resumes.
//  Write: at an edge with wr_i=1 and full_o=0, data_i is pushed.
//   If full_o=1 at that edge, the byte is dropped and overflow_o sets; it stays
//   set until reset.
//   full_o is evaluated before any same-cycle pop: a write to a full FIFO is
//   dropped even if a pop happens in the same cycle.
//  Simultaneous push and pop when not full: both happen; level_o is unchanged.
//  Pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
//  FSM states: IDLE, START, DATA, STOP. Encodings live in the shared include.
//   IDLE:  tx_o=1. If FIFO non-empty: pop into shift reg, go to START.
//   START: tx_o=0 for CLKS_PER_BIT cycles, then go to DATA.
//   DATA:  send shift reg LSB first, CLKS_PER_BIT cycles per bit, 8 bits.
//          A 3-bit bit counter moves to STOP after bit 7.
//   STOP:  tx_o=1 for CLKS_PER_BIT cycles. On the last cycle, if the FIFO is
//          non-empty, pop and go straight to START (no idle gap). Else go IDLE.
//  tx_o is registered.
//  Latency: a write at edge N into an idle, empty block pops at edge N+1, so
//   tx_o falls after edge N+1.
//  Frame length: exactly 10*CLKS_PER_BIT cycles.
//  busy_o is combinational: (state!=IDLE) | (level_o!=0).
//  Baud counter: $clog2(CLKS_PER_BIT) bits. Counts 0..CLKS_PER_BIT-1, then
//   reloads on each bit boundary.
// STRUCTURE
//  src/uart_defs.vh holds the FSM state localparams (2-bit) and default
//  CLKS_PER_BIT. These are shared with a future uart_in_port.
//  One sub-module, sync_fifo (DATA_W, FIFO_DEPTH): push/pop/full/empty/count.
//  uart_out_port holds the FSM, baud counter, bit counter, shift register and
//  overflow flag.
// TESTING (CLKS_PER_BIT=4, FIFO_DEPTH=4)
//  1. Reset 2 cycles -> tx_o=1, busy_o=0, level_o=0, overflow_o=0.
//  2. Single write 0xA5 -> tx_o low 1 cycle after the write edge.
//     Line reads 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles.
//     busy_o drops after exactly 40 cycles.
//  3. Writes 0x41,0x42 on consecutive cycles -> 80-cycle continuous frames,
//     no idle bit between them. Decoded bytes are 0x41 then 0x42.
//  4. Six writes on consecutive cycles, 0x01..0x06 -> 0x01 is popped; 0x02..0x05
//     fill the FIFO (full_o=1, level_o=4); 0x06 is dropped and overflow_o=1.
//     Serial output is 0x01..0x05.
//  5. Assert rst_i at cycle 15 of a 0xFF frame -> tx_o=1 next cycle, FIFO empty,
//     overflow_o cleared. A following write 0x3C transmits correctly.
//  6. CPU integration: connect to the cpu reg_out_o plus the output write strobe.
//     Run a program that writes 0x00..0x03 -> four frames decoded in order.

Source files
------------

// File: rtl/uart_out_port_pkg.sv
// Shared definitions for the UART output port: FSM state encodings and defaults.
package uart_out_port_pkg;

    // 2-bit state encodings, kept here so a future receive port can share them.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    localparam int UART_DATA_W                = 8;
    localparam int UART_FIFO_DEPTH_DEFAULT    = 4;
    localparam int UART_CLKS_PER_BIT_DEFAULT  = 4;

endpackage

// File: rtl/uart_out_port_sync_fifo.sv
// Synchronous FIFO with power-of-two depth; head entry is visible on rd_data_o.
module uart_out_port_sync_fifo
    import uart_out_port_pkg::*;
#(
    parameter int DATA_W     = UART_DATA_W,
    parameter int FIFO_DEPTH = UART_FIFO_DEPTH_DEFAULT
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        push_i,
    input  logic [DATA_W-1:0]           wr_data_i,
    input  logic                        pop_i,
    output logic [DATA_W-1:0]           rd_data_o,
    output logic                        full_o,
    output logic                        empty_o,
    output logic [$clog2(FIFO_DEPTH):0] count_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push_ok;
    logic              pop_ok;

    assign full_o    = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];

    // Pointer and count update; pushes into a full FIFO and pops from an empty one are ignored.
    always_comb begin
        push_ok  = push_i && !full_o;
        pop_ok   = pop_i && !empty_o;
        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end

    // Pointer and count registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage; contents need no reset because the count gates every read.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/uart_out_port.sv
// UART output port: queues CPU output bytes and serializes them as 8N1 frames.
//
//  state    | meaning
//  ---------+-------------------------------------------------------------
//  ST_IDLE  | line high, waiting for a queued byte
//  ST_START | start bit (line low) for one bit time
//  ST_DATA  | eight data bits, LSB first, one bit time each
//  ST_STOP  | stop bit (line high); chains straight into the next frame
module uart_out_port
    import uart_out_port_pkg::*;
#(
    parameter int DATA_W       = UART_DATA_W,
    parameter int FIFO_DEPTH   = UART_FIFO_DEPTH_DEFAULT,
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [DATA_W-1:0]           data_i,
    input  logic                        wr_i,
    output logic                        tx_o,
    output logic                        busy_o,
    output logic                        full_o,
    output logic [$clog2(FIFO_DEPTH):0] level_o,
    output logic                        overflow_o
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    uart_state_e       state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              overflow_q, overflow_d;

    logic              fifo_pop;
    logic              fifo_empty;
    logic              fifo_full;
    logic [DATA_W-1:0] fifo_head;
    logic              baud_last;

    uart_out_port_sync_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push_i    (wr_i),
        .wr_data_i (data_i),
        .pop_i     (fifo_pop),
        .rd_data_o (fifo_head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (level_o)
    );

    assign full_o     = fifo_full;
    assign overflow_o = overflow_q;
    assign tx_o       = tx_q;
    assign busy_o     = (state_q != ST_IDLE) || (level_o != '0);
    assign baud_last  = (baud_q == BAUD_LAST);

    // Next-state, counters and shifter; tx is derived from the next state so the pin is registered.
    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        fifo_pop   = 1'b0;
        // full_o is the pre-pop value, so a write at a full FIFO is dropped even during a pop.
        overflow_d = overflow_q || (wr_i && fifo_full);

        unique case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_head;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = ST_DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_q >> 1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (baud_last) begin
                    baud_d = '0;
                    bit_d  = '0;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_head;
                        state_d  = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        unique case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_d[0];
            default:  tx_d = 1'b1;
        endcase
    end

    // State, counter, shifter, line and sticky overflow registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_uart_out_port.sv
// Bench for uart_out_port: directed writes feed an expected-byte queue; a line monitor decodes frames.
module tb_uart_out_port;

    logic       clk;
    logic       rst;
    logic [7:0] data;
    logic       wr;
    logic       tx;
    logic       busy;
    logic       full;
    logic [2:0] level;
    logic       overflow;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int frames = 0;

    logic [7:0] exp_q[$];
    int         start_q[$];

    uart_out_port #(
        .DATA_W       (8),
        .FIFO_DEPTH   (4),
        .CLKS_PER_BIT (4)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .data_i     (data),
        .wr_i       (wr),
        .tx_o       (tx),
        .busy_o     (busy),
        .full_o     (full),
        .level_o    (level),
        .overflow_o (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] b, input bit expect_tx);
        wr   = 1'b1;
        data = b;
        tick();
        wr   = 1'b0;
        if (expect_tx) exp_q.push_back(b);
    endtask

    task automatic drain(input string name, input int limit);
        int n;
        n = 0;
        while (busy && n < limit) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drain_done"}, {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
    endtask

    // Line monitor: offsets count negedges from the first low sample of a frame.
    initial begin : monitor
        logic [7:0] b;
        logic       sbit;
        logic       pbit;
        logic       aborted;
        int         st;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (!rst && tx === 1'b0) begin
                st      = cyc;
                aborted = 1'b0;
                b       = '0;
                sbit    = 1'b1;
                pbit    = 1'b0;
                for (int k = 1; k <= 39; k++) begin
                    @(negedge clk);
                    if (rst) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (k == 2) sbit = tx;
                    if (k >= 6 && k <= 34 && ((k - 2) % 4) == 0) b[(k - 2) / 4 - 1] = tx;
                    if (k == 38) pbit = tx;
                end
                if (!aborted) begin
                    frames++;
                    start_q.push_back(st);
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL rx_unexpected: got 0x%0h expected no frame", b);
                    end else begin
                        e = exp_q.pop_front();
                        check("rx_byte", {24'd0, b}, {24'd0, e});
                        check("rx_start_bit", {31'd0, sbit}, 32'd0);
                        check("rx_stop_bit", {31'd0, pbit}, 32'd1);
                    end
                end
            end
        end
    end

    initial begin : stim
        logic [9:0] pat;
        int         s0;
        rst  = 1'b1;
        wr   = 1'b0;
        data = 8'h00;

        // 1: reset
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_level", {29'd0, level}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);

        // 2: single 0xA5; line is start, 1,0,1,0,0,1,0,1, stop (index 0 is first on the line)
        tick();
        write_byte(8'hA5, 1'b1);
        @(negedge clk);
        check("a5_queued_level", {29'd0, level}, 32'd1);
        check("a5_queued_busy", {31'd0, busy}, 32'd1);
        check("a5_queued_tx", {31'd0, tx}, 32'd1);
        @(negedge clk);
        pat = 10'b11_0100_1010;
        for (int n = 0; n < 40; n++) begin
            check("a5_line", {31'd0, tx}, {31'd0, pat[n / 4]});
            if (n == 39) check("a5_busy_last", {31'd0, busy}, 32'd1);
            @(negedge clk);
        end
        check("a5_busy_done", {31'd0, busy}, 32'd0);
        check("a5_tx_idle", {31'd0, tx}, 32'd1);
        repeat (3) @(negedge clk);

        // 3: back-to-back frames with no idle gap
        s0 = start_q.size();
        tick();
        write_byte(8'h41, 1'b1);
        write_byte(8'h42, 1'b1);
        drain("b2b", 200);
        check("b2b_frames", start_q.size() - s0, 32'd2);
        if (start_q.size() >= s0 + 2)
            check("b2b_gap", start_q[s0 + 1] - start_q[s0], 32'd40);

        // 4: overflow; 0x01 popped at once, 0x02..0x05 fill the FIFO, 0x06 dropped
        tick();
        for (int i = 1; i <= 6; i++) begin
            write_byte(8'(i), i <= 5);
            if (i == 5) begin
                check("ovf_full", {31'd0, full}, 32'd1);
                check("ovf_level", {29'd0, level}, 32'd4);
                check("ovf_flag_pre", {31'd0, overflow}, 32'd0);
            end
        end
        @(negedge clk);
        check("ovf_flag", {31'd0, overflow}, 32'd1);
        check("ovf_level_after", {29'd0, level}, 32'd4);
        drain("ovf", 400);
        check("ovf_sticky", {31'd0, overflow}, 32'd1);
        check("ovf_empty", {29'd0, level}, 32'd0);

        // 5: reset mid-frame of 0xFF, then 0x3C
        tick();
        write_byte(8'hFF, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("abort_start", {31'd0, tx}, 32'd0);
        repeat (15) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("abort_tx", {31'd0, tx}, 32'd1);
        check("abort_level", {29'd0, level}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_overflow", {31'd0, overflow}, 32'd0);
        repeat (8) @(negedge clk);
        check("abort_no_resume", {31'd0, tx}, 32'd1);
        tick();
        write_byte(8'h3C, 1'b1);
        drain("post_rst", 200);

        // 6: CPU-style writes 0x00..0x03 with irregular spacing
        tick();
        write_byte(8'h00, 1'b1);
        repeat (3) tick();
        write_byte(8'h01, 1'b1);
        write_byte(8'h02, 1'b1);
        repeat (50) tick();
        write_byte(8'h03, 1'b1);
        drain("cpu", 400);

        check("frames_left", exp_q.size(), 32'd0);
        check("frames_total", frames, 32'd13);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always reaches a summary.
    initial begin : watchdog
        #200000;
        bad++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
